// File: rtl/id_pkg.sv
// Shared decode definitions: RV32/64 base opcodes and control-bit layout.
package id_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_ALUI   = 7'b0010011,
    OP_ALU    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  localparam int CTL_IMM = 0;
  localparam int CTL_ST  = 1;
  localparam int CTL_LD  = 2;
  localparam int CTL_BR  = 3;
  localparam int CTL_WR  = 4;
  localparam int CTL_W   = 5;

  typedef logic [CTL_W-1:0] ctl_t;

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface id_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [4:0]      out_ctl;
  logic [3:0]      out_msg;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_ctl, out_msg, out_imm, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_ctl, out_msg, out_imm, out_illegal
  );
endinterface

// File: rtl/fifo.sv
// Generic circular FIFO with synchronous clear (clear beats push/pop); 1-cycle push-to-head.
// Backpressure: wr_rdy drops when full, no push-while-full bypass; rd_rdy pops the head.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign wr_rdy = (count != FULL_CNT);
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign push   = wr_vld && wr_rdy && !clr;
  assign pop    = rd_rdy && rd_vld && !clr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/inst_decode_core.sv
// Combinational RV base-ISA field/immediate/control decoder, XLEN-wide immediates.
// Zero latency, no state; unsupported opcodes flag illegal with ctl and imm forced to 0.
module inst_decode_core
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output ctl_t            ctl,
  output logic [3:0]      msg,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic            rs1_used,
  output logic            rs2_used
);
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rd  = inst[11:7];
  assign msg = {inst[30], inst[14:12]};

  // inst[31] is both the sign and the top immediate bit, so it fills every upper position.
  assign imm_i = {{(XLEN-11){inst[31]}}, inst[30:20]};
  assign imm_s = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
  assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    ctl      = '0;
    imm      = '0;
    illegal  = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (inst[6:0])
      OP_LUI, OP_AUIPC: begin
        ctl[CTL_IMM] = 1'b1;
        ctl[CTL_WR]  = 1'b1;
        imm          = imm_u;
      end
      OP_JAL: begin
        ctl[CTL_IMM] = 1'b1;
        ctl[CTL_BR]  = 1'b1;
        ctl[CTL_WR]  = 1'b1;
        imm          = imm_j;
      end
      OP_JALR: begin
        ctl[CTL_IMM] = 1'b1;
        ctl[CTL_BR]  = 1'b1;
        ctl[CTL_WR]  = 1'b1;
        imm          = imm_i;
        rs1_used     = 1'b1;
      end
      OP_BRANCH: begin
        ctl[CTL_IMM] = 1'b1;
        ctl[CTL_BR]  = 1'b1;
        imm          = imm_b;
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
      OP_LOAD: begin
        ctl[CTL_IMM] = 1'b1;
        ctl[CTL_LD]  = 1'b1;
        ctl[CTL_WR]  = 1'b1;
        imm          = imm_i;
        rs1_used     = 1'b1;
      end
      OP_STORE: begin
        ctl[CTL_IMM] = 1'b1;
        ctl[CTL_ST]  = 1'b1;
        imm          = imm_s;
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
      OP_ALUI: begin
        ctl[CTL_IMM] = 1'b1;
        ctl[CTL_WR]  = 1'b1;
        imm          = imm_i;
        rs1_used     = 1'b1;
      end
      OP_ALU: begin
        ctl[CTL_WR]  = 1'b1;
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: begin
        rs1_used     = 1'b1;
      end
      default: begin
        illegal      = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/id_stage.sv
// Registered decode stage: instruction queue, decoder, valid/ready output register, load-use bubble, flush.
// Latency 1 edge from queue to output; backpressure: holds output while !out_ready, in_ready = !full && !flush.
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } q_ent_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    ctl_t            ctl;
    logic [3:0]      msg;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } out_t;

  q_ent_t          head;
  q_ent_t          wr_ent;
  logic            q_vld;
  logic            q_rdy;
  logic            load_en;

  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  ctl_t            dec_ctl;
  logic [3:0]      dec_msg;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            dec_rs1_used;
  logic            dec_rs2_used;

  out_t            out_q;
  logic            out_valid_q;
  logic            load_v;
  logic [4:0]      load_rd;
  logic            hazard;
  logic            load_xfer;

  assign wr_ent.pc   = bus.in_pc;
  assign wr_ent.inst = bus.in_inst;
  assign bus.in_ready = q_rdy && !bus.flush;

  fifo #(
    .WIDTH ($bits(q_ent_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .clr    (bus.flush),
    .wr_vld (bus.in_valid && !bus.flush),
    .wr_rdy (q_rdy),
    .wr_dat (wr_ent),
    .rd_vld (q_vld),
    .rd_rdy (load_en),
    .rd_dat (head)
  );

  inst_decode_core #(
    .XLEN (XLEN)
  ) u_dec (
    .inst     (head.inst),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .ctl      (dec_ctl),
    .msg      (dec_msg),
    .imm      (dec_imm),
    .illegal  (dec_illegal),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used)
  );

  // The tracker only looks at the cycle right after a load leaves, so the head it guards
  // is the instruction that would otherwise enter the output register behind it.
  assign hazard = load_v && ((dec_rs1_used && (dec_rs1 == load_rd)) ||
                             (dec_rs2_used && (dec_rs2 == load_rd)));

  assign load_en   = (!out_valid_q || bus.out_ready) && q_vld && !hazard && !bus.flush;
  assign load_xfer = out_valid_q && bus.out_ready && out_q.ctl[CTL_LD] && (out_q.rd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (load_en) begin
      out_valid_q   <= 1'b1;
      out_q.pc      <= head.pc;
      out_q.rs1     <= dec_rs1;
      out_q.rs2     <= dec_rs2;
      out_q.rd      <= dec_rd;
      out_q.ctl     <= dec_ctl;
      out_q.msg     <= dec_msg;
      out_q.imm     <= dec_imm;
      out_q.illegal <= dec_illegal;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_v  <= 1'b0;
      load_rd <= '0;
    end else begin
      load_v <= load_xfer && !bus.flush;
      if (load_xfer) begin
        load_rd <= out_q.rd;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_ctl     = out_q.ctl;
  assign bus.out_msg     = out_q.msg;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_illegal = out_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: XLEN=32 and XLEN=64 instances share stimulus, one monitor checks both.
module tb_id_stage;
  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_ready;

  id_stage_if #(.XLEN(32)) b32 ();
  id_stage_if #(.XLEN(64)) b64 ();

  assign b32.flush     = flush;
  assign b32.in_valid  = in_valid;
  assign b32.in_inst   = in_inst;
  assign b32.in_pc     = in_pc[31:0];
  assign b32.out_ready = out_ready;
  assign b64.flush     = flush;
  assign b64.in_valid  = in_valid;
  assign b64.in_inst   = in_inst;
  assign b64.in_pc     = in_pc;
  assign b64.out_ready = out_ready;

  id_stage #(.XLEN(32), .QDEPTH(2)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
  id_stage #(.XLEN(64), .QDEPTH(2)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  ctl;
    logic [3:0]  msg;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   xfer_at[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   last_acc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [4:0] ctl, input logic [3:0] msg, input logic [63:0] imm,
                              input logic ill);
    exp_t e;
    e.pc = '0; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.ctl = ctl; e.msg = msg; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  task automatic check_out(input string tag, input logic [63:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic [4:0] ctl,
                           input logic [3:0] msg, input logic [63:0] imm, input logic ill,
                           input exp_t e, input bit narrow);
    cmp({tag, "_pc"},  pc,  e.pc);
    cmp({tag, "_rs1"}, 64'(rs1), 64'(e.rs1));
    cmp({tag, "_rs2"}, 64'(rs2), 64'(e.rs2));
    cmp({tag, "_rd"},  64'(rd),  64'(e.rd));
    cmp({tag, "_ctl"}, 64'(ctl), 64'(e.ctl));
    cmp({tag, "_msg"}, 64'(msg), 64'(e.msg));
    cmp({tag, "_imm"}, imm, narrow ? {32'b0, e.imm[31:0]} : e.imm);
    cmp({tag, "_illegal"}, 64'(ill), 64'(e.ill));
  endtask

  // Monitor: every accepted output is matched against the head of its expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (b32.out_valid && b32.out_ready) begin
        xfer_at.push_back(cyc);
        if (q32.size() == 0) cmp("out32_unexpected", 64'd1, 64'd0);
        else check_out("out32", {32'b0, b32.out_pc}, b32.out_rs1, b32.out_rs2, b32.out_rd,
                       b32.out_ctl, b32.out_msg, {32'b0, b32.out_imm}, b32.out_illegal,
                       q32.pop_front(), 1'b1);
      end
      if (b64.out_valid && b64.out_ready) begin
        if (q64.size() == 0) cmp("out64_unexpected", 64'd1, 64'd0);
        else check_out("out64", b64.out_pc, b64.out_rs1, b64.out_rs2, b64.out_rd,
                       b64.out_ctl, b64.out_msg, b64.out_imm, b64.out_illegal,
                       q64.pop_front(), 1'b0);
      end
    end
  end

  task automatic push(input logic [31:0] inst, input logic [63:0] pc, input exp_t e);
    int n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    forever begin
      @(negedge clk);
      if (b32.in_ready) break;
      n++;
      if (n > 200) begin
        cmp("push_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
        return;
      end
    end
    e.pc = pc;
    q32.push_back(e);
    q64.push_back(e);
    last_acc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q32.size() != 0 || q64.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        cmp("drain_timeout", 64'(q32.size()), 64'd0);
        q32.delete();
        q64.delete();
      end
    end
    idle(3);
  endtask

  task automatic check_zero_outputs(input string tag);
    cmp({tag, "_out_valid"}, 64'(b32.out_valid), 64'd0);
    cmp({tag, "_in_ready"},  64'(b32.in_ready),  64'd1);
    cmp({tag, "_out_pc"},    64'(b32.out_pc),    64'd0);
    cmp({tag, "_out_rd"},    64'(b32.out_rd),    64'd0);
    cmp({tag, "_out_ctl"},   64'(b32.out_ctl),   64'd0);
    cmp({tag, "_out_illegal"}, 64'(b32.out_illegal), 64'd0);
    cmp({tag, "_out_imm64"}, b64.out_imm,        64'd0);
    cmp({tag, "_out_valid64"}, 64'(b64.out_valid), 64'd0);
  endtask

  int          n0;
  logic [31:0] w;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    #2;
    check_zero_outputs("reset");
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // addi x1,x2,5: one edge from acceptance to output register
    out_ready = 1'b1;
    push(32'h00510093, 64'h100, mk(5'd2, 5'd5, 5'd1, 5'b10001, 4'h0, 64'd5, 1'b0));
    drain();
    cmp("addi_latency", 64'(xfer_at[$] - last_acc), 64'd2);

    // lw x5,0(x1) then dependent add x6,x5,x7: one bubble
    n0 = xfer_at.size();
    push(32'h0000A283, 64'h104, mk(5'd1, 5'd0, 5'd5, 5'b10101, 4'h2, 64'd0, 1'b0));
    idle(1);
    push(32'h00728333, 64'h108, mk(5'd5, 5'd7, 5'd6, 5'b10000, 4'h0, 64'd0, 1'b0));
    drain();
    if (xfer_at.size() >= n0 + 2) cmp("loaduse_gap", 64'(xfer_at[n0+1] - xfer_at[n0]), 64'd3);
    else cmp("loaduse_count", 64'(xfer_at.size() - n0), 64'd2);

    // independent add x6,x4,x7 after lw: no bubble
    n0 = xfer_at.size();
    push(32'h0000A283, 64'h10C, mk(5'd1, 5'd0, 5'd5, 5'b10101, 4'h2, 64'd0, 1'b0));
    idle(1);
    push(32'h00720333, 64'h110, mk(5'd4, 5'd7, 5'd6, 5'b10000, 4'h0, 64'd0, 1'b0));
    drain();
    if (xfer_at.size() >= n0 + 2) cmp("nodep_gap", 64'(xfer_at[n0+1] - xfer_at[n0]), 64'd2);
    else cmp("nodep_count", 64'(xfer_at.size() - n0), 64'd2);

    // lw x0 never arms the tracker, even against add x6,x0,x7
    n0 = xfer_at.size();
    push(32'h0000A003, 64'h114, mk(5'd1, 5'd0, 5'd0, 5'b10101, 4'h2, 64'd0, 1'b0));
    idle(1);
    push(32'h00700333, 64'h118, mk(5'd0, 5'd7, 5'd6, 5'b10000, 4'h0, 64'd0, 1'b0));
    drain();
    if (xfer_at.size() >= n0 + 2) cmp("x0_gap", 64'(xfer_at[n0+1] - xfer_at[n0]), 64'd2);
    else cmp("x0_count", 64'(xfer_at.size() - n0), 64'd2);

    // Stalled output: exactly 3 accepted, then release and stream 10 in order
    out_ready = 1'b0;
    acc_cnt = 0;
    n0 = xfer_at.size();
    fork
      begin
        for (int i = 1; i <= 10; i++) begin
          w = {12'(i), 5'd0, 3'b000, 5'(i), 7'b0010011};
          push(w, 64'(32'h200 + 4 * i), mk(5'd0, 5'(i), 5'(i), 5'b10001, 4'h0, 64'(i), 1'b0));
        end
      end
      begin
        repeat (8) @(negedge clk);
        cmp("stall_accepted", 64'(acc_cnt), 64'd3);
        cmp("stall_in_ready", 64'(b32.in_ready), 64'd0);
        cmp("stall_hold_rd", 64'(b32.out_rd), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    cmp("stream_xfers", 64'(xfer_at.size() - n0), 64'd10);

    // Flush with output valid and two queued; an offer during flush is refused
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(32'h00510093, 64'h300 + 64'(4 * i), mk(5'd2, 5'd5, 5'd1, 5'b10001, 4'h0, 64'd5, 1'b0));
    flush = 1'b1;
    in_valid = 1'b1;
    in_inst = 32'h00510093;
    in_pc = 64'h3F0;
    @(negedge clk);
    cmp("flush_in_ready", 64'(b32.in_ready), 64'd0);
    cmp("preflush_out_valid", 64'(b32.out_valid), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q32.delete();
    q64.delete();
    @(negedge clk);
    cmp("postflush_out_valid", 64'(b32.out_valid), 64'd0);
    cmp("postflush_in_ready", 64'(b32.in_ready), 64'd1);
    out_ready = 1'b1;
    idle(2);
    // jal x0,16 after flush
    push(32'h0100006F, 64'h400, mk(5'd0, 5'd16, 5'd0, 5'b11001, 4'h0, 64'd16, 1'b0));
    drain();

    // Illegal opcode and immediate formats
    push(32'hFFFFFFFF, 64'h500, mk(5'd31, 5'd31, 5'd31, 5'b00000, 4'hF, 64'd0, 1'b1));
    push(32'hFE000EE3, 64'h504, mk(5'd0, 5'd0, 5'd29, 5'b01001, 4'h8, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0));
    push(32'h800001B7, 64'h508, mk(5'd0, 5'd0, 5'd3, 5'b10001, 4'h0, 64'hFFFF_FFFF_8000_0000, 1'b0));
    push(32'hFE20AC23, 64'h50C, mk(5'd1, 5'd2, 5'd24, 5'b00011, 4'hA, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0));
    push(32'h00000073, 64'h510, mk(5'd0, 5'd0, 5'd0, 5'b00000, 4'h0, 64'd0, 1'b0));
    push(32'h004280E7, 64'h514, mk(5'd5, 5'd4, 5'd1, 5'b11001, 4'h0, 64'd4, 1'b0));
    drain();

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(32'h00510093, 64'h600 + 64'(4 * i), mk(5'd2, 5'd5, 5'd1, 5'b10001, 4'h0, 64'd5, 1'b0));
    @(negedge clk);
    cmp("prereset_out_valid", 64'(b32.out_valid), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    q32.delete();
    q64.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(1);
    push(32'h00510093, 64'h700, mk(5'd2, 5'd5, 5'd1, 5'b10001, 4'h0, 64'd5, 1'b0));
    drain();

    cmp("leftover_expected", 64'(q32.size() + q64.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Parametrised, registered instruction-decode stage for the 5-stage RISC-V core.
- Buffers fetched instructions in a small queue.
- Decodes the head instruction into register indices, control bits, a msg field and an XLEN-wide immediate.
- Presents the result through a valid/ready output register.
- Adds one-cycle load-use bubble insertion, illegal-opcode flagging and pipeline flush, none of which the combinational decoder had.

Parameters:
XLEN, 32, datapath/immediate/PC width; 32 or 64 only.
QDEPTH, 2, instruction queue entries; power of two, ≥2.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
flush  in  1  discard all buffered and registered instructions
in_valid  in  1  fetch offers an instruction
in_ready  out  1  stage can accept
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded instruction valid
out_ready  in  1  execute stage accepts
out_pc  out  XLEN  PC of decoded instruction
out_rs1 / out_rs2 / out_rd  out  5 each  inst[19:15] / [24:20] / [11:7]
out_ctl  out  5  [0] use imm, [1] store, [2] load, [3] branch/jump (B, JAL, JALR), [4] writes rd
out_msg  out  4  {inst[30], inst[14:12]}
out_imm  out  XLEN  sign-extended immediate
out_illegal  out  1  opcode not in the supported set

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-high.
- Reset values: all out_* = 0; queue empty; pointers = 0; load-hazard tracker cleared.
- in_ready = !full && !flush. A push happens on in_valid && in_ready.
- Queue:
  - Circular buffer; read/write pointers wrap modulo QDEPTH.
  - Count kept in clog2(QDEPTH)+1 bits.
  - Full pushes are refused; there is no same-cycle push-while-full bypass.
- Output register load:
  - Loads when (!out_valid || out_ready) && queue non-empty && !hazard && !flush. The head is popped in the same cycle.
  - If out_valid && out_ready and nothing loads, out_valid clears.
  - Output holds stable while out_valid && !out_ready.
- Latency: an instruction accepted at edge k is at the output after edge k+1 at the earliest (2-cycle throughput floor is not imposed; 1 instr/cycle sustained).
- Immediates, all sign-extended from inst[31] to XLEN:
  - I: {inst[31:20]}.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}; sign-extended for XLEN=64.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - ALU-R, FENCE, SYSTEM: 0.
- Control bits:
  - use_imm = 0 for ALU-R, FENCE, SYSTEM; 1 otherwise.
  - writes_rd = LUI, AUIPC, JAL, JALR, LOAD, ALUI, ALU-R.
  - rs1 used = all except LUI, AUIPC, JAL.
  - rs2 used = B, STORE, ALU-R.
- Illegal opcode: out_illegal = 1, out_ctl = 0, out_imm = 0. The instruction still flows; it is not dropped.
- Load-use hazard:
  - When a load with rd ≠ 0 transfers out (out_valid && out_ready && ctl[2]), load_rd is captured and load_v is set for exactly the next cycle.
  - In that cycle, hazard = load_v && ((rs1 used && head.rs1 == load_rd) || (rs2 used && head.rs2 == load_rd)).
  - On hazard the output register does not load (bubble, out_valid = 0) and the head stays queued.
  - load_v clears unconditionally after one cycle.
- Flush:
  - At the next edge: queue empty, out_valid = 0, load_v = 0.
  - An in_valid in the flush cycle is not accepted (in_ready = 0).
  - Flush has priority over any simultaneous push, pop or load.
- Reset mid-operation: all state cleared asynchronously; in-flight instructions are lost.

Decomposition:
- Package id_pkg: opcode constants (LUI, AUIPC, JAL, JALR, B, LOAD, STORE, ALUI, ALU, FENCE, SYSTEM) and ctl bit indices (CTL_IMM=0, CTL_ST=1, CTL_LD=2, CTL_BR=3, CTL_WR=4).
- Sub-module inst_decode_core: purely combinational, parametrised by XLEN. Takes the instruction word and produces rs1/rs2/rd, ctl, msg, imm, illegal, rs1_used and rs2_used.
- id_stage holds the queue, output register, hazard tracker and flush logic.

Test Plan:
- Reset release, push 0x00510093 (addi x1,x2,5) with out_ready=1 -> out_valid one cycle after acceptance; rd=1, rs1=2, imm=5, ctl=5'b10001, msg=0, illegal=0.
- Push 0x0000A283 (lw x5,0(x1)) then 0x00728333 (add x6,x5,x7), out_ready=1 -> lw out; next cycle out_valid=0 (bubble); add out the following cycle with ctl=5'b10000, rs2=7.
- QDEPTH=2, out_ready=0, in_valid held -> exactly 3 instructions accepted (1 in output reg, 2 queued), then in_ready=0. Raise out_ready -> order preserved; pointers wrap with no loss or duplication over 10 pushes.
- Queue holds 2 entries and out_valid=1, assert flush for 1 cycle -> next cycle out_valid=0, in_ready=1; a later push appears normally.
- Push 0xFFFFFFFF -> out_illegal=1, ctl=0, imm=0. XLEN=64, push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFF_FFFF_FFFF_FFFC, ctl[3]=1.
- Assert rst asynchronously while out_valid=1 and queue non-empty -> all outputs 0 immediately, without a clock edge.
